// File: rtl/timer_slave_if.sv
// Data-memory bus between the CPU-side master and the timer responder.
// ram_en is the request valid; the slave is always ready, so every request
// with ram_en=1 completes in the cycle it is presented (reads same cycle,
// writes at the next rising edge). No request is ever stalled or queued.
interface timer_slave_if;
  logic        ram_en;
  logic        wr_en;
  logic [3:0]  Bits_Sel;
  logic [31:0] ram_addr_i;
  logic [31:0] data_to_ram;
  logic [31:0] data_from_ram;

  modport master (
    output ram_en, wr_en, Bits_Sel, ram_addr_i, data_to_ram,
    input  data_from_ram
  );

  modport slave (
    input  ram_en, wr_en, Bits_Sel, ram_addr_i, data_to_ram,
    output data_from_ram
  );
endinterface

// File: rtl/timer_slave.sv
// Memory-mapped prescaled 32-bit timer with compare, auto-reload/one-shot
// modes and a level interrupt (PEND & IE).
module timer_slave #(
  parameter int                 DATA_W  = 32,
  parameter int                 PRESC_W = 8,
  parameter logic [DATA_W-1:0]  CMP_RST = 32'hFFFF_FFFF
) (
  input  logic          clk,
  input  logic          rst_n,
  timer_slave_if.slave  bus,
  output logic          timer_interrupt
);

  localparam logic [1:0] OFF_CTRL    = 2'd0;
  localparam logic [1:0] OFF_COUNT   = 2'd1;
  localparam logic [1:0] OFF_COMPARE = 2'd2;
  localparam logic [1:0] OFF_STATUS  = 2'd3;

  logic               en_q, en_d;
  logic               ar_q, ar_d;
  logic               ie_q, ie_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] psc_q, psc_d;
  logic [DATA_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0]  compare_q, compare_d;
  logic               pend_q, pend_d;

  logic               wr, rd, tick, pend_set, pend_clr;
  logic [1:0]         off;
  logic [DATA_W-1:0]  ctrl_merged;
  logic [DATA_W-1:0]  rd_data;
  logic               unused_addr;

  function automatic logic [DATA_W-1:0] lane_merge(input logic [DATA_W-1:0] cur,
                                                   input logic [DATA_W-1:0] wdata,
                                                   input logic [3:0]        sel);
    logic [DATA_W-1:0] r;
    r = cur;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) r[8*i +: 8] = wdata[8*i +: 8];
    end
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] ctrl_pack(input logic en, input logic ar,
                                                  input logic ie,
                                                  input logic [PRESC_W-1:0] presc);
    logic [DATA_W-1:0] r;
    r = '0;
    r[0] = en;
    r[1] = ar;
    r[2] = ie;
    r[8 +: PRESC_W] = presc;
    return r;
  endfunction

  assign wr  = bus.ram_en & bus.wr_en;
  assign rd  = bus.ram_en & ~bus.wr_en;
  assign off = bus.ram_addr_i[3:2];
  assign unused_addr = ^{bus.ram_addr_i[31:4], bus.ram_addr_i[1:0]};

  always_comb begin
    en_d        = en_q;
    ar_d        = ar_q;
    ie_d        = ie_q;
    presc_d     = presc_q;
    psc_d       = '0;
    count_d     = count_q;
    compare_d   = compare_q;
    tick        = 1'b0;
    pend_set    = 1'b0;
    pend_clr    = 1'b0;
    ctrl_merged = '0;

    if (en_q) begin
      if (psc_q == presc_q) tick = 1'b1;
      else                  psc_d = psc_q + 1'b1;
    end

    if (tick) begin
      if (count_q != compare_q) begin
        count_d = count_q + 1'b1;
      end else begin
        pend_set = 1'b1;
        if (ar_q) count_d = '0;
        else      en_d    = 1'b0;
      end
    end

    // Bus writes land on top of the timer's own update, so written bytes win.
    // COUNT merges onto the current value: unwritten bytes hold, no increment.
    if (wr) begin
      unique case (off)
        OFF_CTRL: begin
          ctrl_merged = lane_merge(ctrl_pack(en_d, ar_d, ie_d, presc_d),
                                   bus.data_to_ram, bus.Bits_Sel);
          en_d    = ctrl_merged[0];
          ar_d    = ctrl_merged[1];
          ie_d    = ctrl_merged[2];
          presc_d = ctrl_merged[8 +: PRESC_W];
        end
        OFF_COUNT:   count_d   = lane_merge(count_q, bus.data_to_ram, bus.Bits_Sel);
        OFF_COMPARE: compare_d = lane_merge(compare_q, bus.data_to_ram, bus.Bits_Sel);
        OFF_STATUS:  pend_clr  = bus.Bits_Sel[0] & bus.data_to_ram[0];
        default: ;
      endcase
    end

    // A match in the same cycle as a W1C keeps PEND set.
    pend_d = pend_set | (pend_q & ~pend_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q      <= 1'b0;
      ar_q      <= 1'b0;
      ie_q      <= 1'b0;
      presc_q   <= '0;
      psc_q     <= '0;
      count_q   <= '0;
      compare_q <= CMP_RST;
      pend_q    <= 1'b0;
    end else begin
      en_q      <= en_d;
      ar_q      <= ar_d;
      ie_q      <= ie_d;
      presc_q   <= presc_d;
      psc_q     <= psc_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      pend_q    <= pend_d;
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd) begin
      unique case (off)
        OFF_CTRL:    rd_data = ctrl_pack(en_q, ar_q, ie_q, presc_q);
        OFF_COUNT:   rd_data = count_q;
        OFF_COMPARE: rd_data = compare_q;
        OFF_STATUS:  rd_data[0] = pend_q;
        default: ;
      endcase
    end
  end

  assign bus.data_from_ram = rd_data;
  assign timer_interrupt   = pend_q & ie_q;

endmodule

// File: tb/tb_timer_slave.sv
// Self-checking bench for timer_slave: bus driver tasks, a scoreboard of
// expected {timer_interrupt, read data} words, and a one-line summary.
module tb_timer_slave;

  logic clk;
  logic rst_n;
  logic timer_interrupt;

  timer_slave_if bus_if ();

  timer_slave dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus_if),
    .timer_interrupt (timer_interrupt)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [32:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got irq/data %h required %h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] scramble_addr(input logic [31:0] addr);
    logic [31:0] a;
    a = addr;
    a[31:4] = 28'($urandom());
    a[1:0]  = 2'($urandom_range(0, 3));
    return a;
  endfunction

  task automatic bus_idle();
    bus_if.ram_en      = 1'b0;
    bus_if.wr_en       = 1'b0;
    bus_if.Bits_Sel    = 4'h0;
    bus_if.ram_addr_i  = 32'h0;
    bus_if.data_to_ram = 32'h0;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] sel);
    bus_if.ram_en      = 1'b1;
    bus_if.wr_en       = 1'b1;
    bus_if.Bits_Sel    = sel;
    bus_if.ram_addr_i  = scramble_addr(addr);
    bus_if.data_to_ram = data;
    @(posedge clk);
    #1;
    bus_idle();
  endtask

  task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp_d,
                          input logic exp_irq, input string tag);
    exp_q.push_back({exp_irq, exp_d});
    bus_if.ram_en      = 1'b1;
    bus_if.wr_en       = 1'b0;
    bus_if.Bits_Sel    = 4'($urandom_range(0, 15));
    bus_if.ram_addr_i  = scramble_addr(addr);
    bus_if.data_to_ram = $urandom();
    @(negedge clk);
    check(tag, {timer_interrupt, bus_if.data_from_ram}, exp_q.pop_front());
    @(posedge clk);
    #1;
    bus_idle();
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    bus_idle();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_cycles(1);

    // Reset values
    bus_read(32'h0, 32'h0,         1'b0, "rst_ctrl");
    bus_read(32'h4, 32'h0,         1'b0, "rst_count");
    bus_read(32'h8, 32'hFFFF_FFFF, 1'b0, "rst_compare");
    bus_read(32'hC, 32'h0,         1'b0, "rst_status");
    bus_if.ram_addr_i = 32'h8;
    @(negedge clk);
    check("idle_reads_zero", {timer_interrupt, bus_if.data_from_ram}, 33'h0);
    idle_cycles(1);

    // Byte lanes, no-op strobes, W1C on an idle STATUS
    bus_write(32'h8, 32'h0, 4'hF);
    bus_write(32'h8, 32'hAABB_CCDD, 4'b0101);
    bus_read(32'h8, 32'h00BB_00DD, 1'b0, "lane_write");
    bus_write(32'h8, 32'h1234_5678, 4'b0000);
    bus_read(32'h8, 32'h00BB_00DD, 1'b0, "lane_noop");
    bus_write(32'hC, 32'h0000_0001, 4'hF);
    bus_read(32'hC, 32'h0, 1'b0, "status_w1c_idle");

    // Periodic: COMPARE=3, EN|AR|IE, PRESC=0
    bus_write(32'h8, 32'h3, 4'hF);
    bus_write(32'h0, 32'h7, 4'hF);
    for (int i = 0; i < 4; i++) bus_read(32'h4, 32'(i), 1'b0, "per_count");
    bus_read(32'hC, 32'h1, 1'b1, "per_pend");
    bus_write(32'hC, 32'h1, 4'b0001);
    bus_read(32'h4, 32'h2, 1'b0, "per_after_clr");
    bus_read(32'h4, 32'h3, 1'b0, "per_before_match");
    bus_read(32'hC, 32'h1, 1'b1, "per_second_match");

    bus_write(32'h0, 32'h0, 4'hF);
    bus_write(32'hC, 32'h1, 4'hF);
    bus_write(32'h4, 32'h0, 4'hF);
    bus_read(32'hC, 32'h0, 1'b0, "clean_status");

    // Prescaler and one-shot: COMPARE=2, EN|IE, PRESC=2
    bus_write(32'h8, 32'h2, 4'hF);
    bus_write(32'h0, 32'h205, 4'hF);
    for (int i = 0; i < 9; i++) bus_read(32'h4, 32'(i / 3), 1'b0, "psc_count");
    bus_read(32'h0, 32'h204, 1'b1, "os_en_cleared");
    bus_read(32'h4, 32'h2, 1'b1, "os_count");
    idle_cycles(3);
    bus_read(32'h4, 32'h2, 1'b1, "os_hold");

    bus_write(32'hC, 32'h1, 4'hF);
    bus_write(32'h0, 32'h0, 4'hF);

    // Wrap through 2^32, then collisions
    bus_write(32'h4, 32'hFFFF_FFFE, 4'hF);
    bus_write(32'h8, 32'h1, 4'hF);
    bus_write(32'h0, 32'h7, 4'hF);
    bus_read(32'h4, 32'hFFFF_FFFE, 1'b0, "wrap_fffe");
    bus_read(32'h4, 32'hFFFF_FFFF, 1'b0, "wrap_ffff");
    bus_read(32'h4, 32'h0,         1'b0, "wrap_zero");
    bus_read(32'h4, 32'h1,         1'b0, "wrap_one");
    bus_read(32'hC, 32'h1,         1'b1, "wrap_pend");
    bus_write(32'hC, 32'h1, 4'b0001);
    bus_read(32'hC, 32'h1, 1'b1, "w1c_vs_match");
    bus_write(32'h4, 32'h100, 4'hF);
    bus_read(32'h4, 32'h100, 1'b1, "count_wr_on_tick");
    bus_read(32'h4, 32'h101, 1'b1, "count_resumes");
    bus_write(32'h4, 32'h55, 4'b0001);
    bus_read(32'h4, 32'h155, 1'b1, "count_partial_wr");

    // Asynchronous reset pulse in the middle of a cycle
    bus_write(32'h0, 32'h4, 4'hF);
    bus_write(32'h4, 32'h5, 4'hF);
    bus_read(32'h4, 32'h5, 1'b1, "pre_rst_count");
    bus_read(32'hC, 32'h1, 1'b1, "pre_rst_pend");
    #1;
    rst_n = 1'b0;
    bus_if.ram_en = 1'b1;
    bus_if.wr_en  = 1'b0;
    bus_if.ram_addr_i = 32'h0;
    #1;
    check("arst_ctrl", {timer_interrupt, bus_if.data_from_ram}, 33'h0);
    bus_if.ram_addr_i = 32'h4;
    #1;
    check("arst_count", {timer_interrupt, bus_if.data_from_ram}, 33'h0);
    bus_if.ram_addr_i = 32'hC;
    #1;
    check("arst_status", {timer_interrupt, bus_if.data_from_ram}, 33'h0);
    rst_n = 1'b1;
    bus_idle();
    @(posedge clk);
    #1;
    bus_read(32'h8, 32'hFFFF_FFFF, 1'b0, "post_rst_compare");
    bus_read(32'h4, 32'h0,         1'b0, "post_rst_count");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
